// File: rtl/seg7_pkg.sv
// Shared types and glyph data for the seg7_display_ctrl slice.
// Glyphs are stored active-high; polarity is applied in seg7_encoder.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } state_e;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int unsigned dig_lsb(input int unsigned i);
    return i * 4;
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Nibble to 7-segment pattern; blank wins over dash, dash over glyph.
// Output polarity follows SEG_ACTIVE_LOW.
module seg7_encoder
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  logic [6:0] pat;

  always_comb begin
    pat = GLYPH[nib_i];
    if (dash_i)  pat = SEG_DASH;
    if (blank_i) pat = SEG_BLANK;
    seg_o = SEG_ACTIVE_LOW ? ~pat : pat;
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: hex or double-dabble decimal.
// Optional blinking is built only when SEG7_BLINK_EN is defined.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 5,
  parameter int DATA_W         = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int BLINK_DIV      = 25_000_000
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [DATA_W-1:0]       load_data,
  input  logic                    mode_hex,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    busy,
  output logic                    overflow,
  output logic [NUM_DIGITS*7-1:0] seg_pins
);

  localparam int HW = NUM_DIGITS * 4;
  localparam int BW = HW + 4;
  localparam int CW = $clog2(DATA_W);
  localparam logic [NUM_DIGITS*7-1:0] SEG_OFF =
    {(NUM_DIGITS*7){SEG_ACTIVE_LOW}};

  state_e state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [BW-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hex_q, hex_d, blz_q, blz_d;
  logic lost_q, lost_d;
  logic ready_q, ready_d, busy_q, busy_d;
  logic ovf_q, ovf_d;
  logic [NUM_DIGITS*7-1:0] seg_q, seg_d;

  logic upd, ovf_new, seg_show, nz;
  logic [DATA_W+HW-1:0] hex_ext;
  logic [3:0] nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz;
  logic [3:0] enc_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] enc_blank;
  logic enc_dash;
  logic [NUM_DIGITS*7-1:0] enc_seg;

  assign upd     = (state_q == UPDATE);
  assign hex_ext = {{HW{1'b0}}, data_q};

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i <= NUM_DIGITS; i++) begin
      if (bcd_q[dig_lsb(i) +: 4] >= 4'd5)
        adj[dig_lsb(i) +: 4] = bcd_q[dig_lsb(i) +: 4] + 4'd3;
    end
  end

  // lost_q catches carries shifted past the extra BCD digit
  always_comb begin
    ovf_new = hex_q ? (|(hex_ext >> HW))
                    : (lost_q | (|bcd_q[BW-1:HW]));
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = hex_q ? hex_ext[dig_lsb(i) +: 4]
                     : bcd_q[dig_lsb(i) +: 4];
    end
    nz = 1'b0;
    lz = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      nz    = nz | (nib[i] != 4'd0);
      lz[i] = blz_q & ~nz;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BCW = $clog2(BLINK_DIV + 1);

  logic [BCW-1:0] bcnt_q;
  logic phase_q, shown_q;
  logic [3:0] nib_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      shown_q <= 1'b0;
      lz_q    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) nib_q[i] <= 4'd0;
    end else begin
      if (bcnt_q == BCW'(BLINK_DIV - 1)) begin
        bcnt_q  <= '0;
        phase_q <= ~phase_q;
      end else begin
        bcnt_q <= bcnt_q + BCW'(1);
      end
      if (upd) begin
        shown_q <= 1'b1;
        lz_q    <= lz;
        nib_q   <= nib;
      end
    end
  end

  // image is re-encoded every cycle so mask changes apply at once
  always_comb begin
    enc_dash = upd ? ovf_new : ovf_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      enc_nib[i]   = upd ? nib[i] : nib_q[i];
      enc_blank[i] = (upd ? lz[i] : lz_q[i])
                   | ~(upd | shown_q)
                   | (phase_q & blink_mask[i]);
    end
  end

  assign seg_show = 1'b1;
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;

  always_comb begin
    enc_dash  = ovf_new;
    enc_blank = lz;
    for (int i = 0; i < NUM_DIGITS; i++) enc_nib[i] = nib[i];
  end

  assign seg_show = upd;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    seg7_encoder #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_enc (
      .nib_i  (enc_nib[g]),
      .blank_i(enc_blank[g]),
      .dash_i (enc_dash),
      .seg_o  (enc_seg[g*7 +: 7])
    );
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    blz_d   = blz_q;
    lost_d  = lost_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid && ready_q) begin
          data_d  = load_data;
          hex_d   = mode_hex;
          blz_d   = blank_lz;
          bcd_d   = '0;
          lost_d  = 1'b0;
          cnt_d   = '0;
          state_d = mode_hex ? UPDATE : CONVERT;
        end
      end
      CONVERT: begin
        bcd_d  = {adj[BW-2:0], data_q[DATA_W-1]};
        lost_d = lost_q | adj[BW-1];
        data_d = data_q << 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        ovf_d   = ovf_new;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    seg_d   = seg_show ? enc_seg : seg_q;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == CONVERT);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      blz_q   <= 1'b0;
      lost_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= SEG_OFF;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      blz_q   <= blz_d;
      lost_q  <= lost_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
    end
  end

  assign load_ready = ready_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign seg_pins   = seg_q;

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
Parametrised multi-digit 7-segment display controller, successor to the fixed five-display, 7-bit-per-digit export.
- Accepts a binary value over a valid/ready handshake.
- Converts it to decimal (sequential double-dabble) or hex.
- Applies leading-zero blanking and overflow indication.
- Drives NUM_DIGITS registered segment patterns on one flat pin bus.
- Sits between the processor-side PIO/register and the board 7-segment pins.

Parameters:
NUM_DIGITS, 5, number of 7-segment digits driven (1..8)
DATA_W, 16, width of load_data (4..32)
SEG_ACTIVE_LOW, 1, 1 = segment on when pin is 0; 0 = on when 1
BLINK_DIV, 25_000_000, clock cycles per blink half-period (only with SEG7_BLINK_EN)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
load_valid  in  1  load request; load_data/mode_hex/blank_lz held stable while high
load_ready  out  1  high when a load can be accepted (IDLE)
load_data  in  DATA_W  unsigned value to display
mode_hex  in  1  1 = hexadecimal digits, 0 = decimal
blank_lz  in  1  1 = blank leading zeros
blink_mask  in  NUM_DIGITS  per-digit blink enable (ignored without SEG7_BLINK_EN)
busy  out  1  conversion in progress
overflow  out  1  last accepted value did not fit in NUM_DIGITS digits
seg_pins  out  NUM_DIGITS*7  digit i on [7i+6:7i]; bit0=a … bit6=g; digit 0 = least significant

Behaviour:
- Clock and reset: single clock clk_clk; reset_reset_n asynchronous, active-low.
- Reset values:
  - seg_pins all segments off (7'h7F per digit when SEG_ACTIVE_LOW=1).
  - load_ready=1, busy=0, overflow=0.
  - FSM in IDLE; blink counter and phase cleared.
- FSM states:
  - IDLE: load_ready=1. On load_valid & load_ready (cycle T), capture data, mode_hex and blank_lz; go to CONVERT if decimal, UPDATE if hex.
  - CONVERT: busy=1. Double-dabble, one input bit per cycle. Exactly DATA_W cycles, then go to UPDATE.
  - UPDATE: one cycle. Compute overflow and blanking, register seg_pins and overflow, return to IDLE.
- Handshake: load_ready falls at T+1 and rises again on return to IDLE. load_valid while load_ready=0 is ignored; there is no queuing.
- Latency: new seg_pins visible at T+2 in hex mode and at T+DATA_W+2 in decimal mode. seg_pins hold their old value until then.
- BCD arithmetic: internal BCD register has NUM_DIGITS+1 digits. Before each shift, add 3 to every digit ≥5.
- Overflow:
  - Decimal: any nonzero bit above NUM_DIGITS*4 after conversion.
  - Hex: load_data has a nonzero bit at index ≥ NUM_DIGITS*4.
  - On overflow, every digit shows dash (g only; 7'h3F active-low) and overflow=1. Otherwise overflow=0.
- Leading-zero blanking: with blank_lz=1, digits above the most significant nonzero digit are off. Digit 0 is never blanked, so value 0 shows "0".
- Encoding (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. With SEG_ACTIVE_LOW=0, outputs are the bitwise inverse.
- Reset mid-conversion: aborts immediately; outputs return to reset values.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
SEG7_BLINK_EN
- With the macro defined:
  - A free-running counter toggles blink_phase every BLINK_DIV cycles.
  - When blink_phase=1, digits with blink_mask[i]=1 are forced off. Overflow dashes blink as well.
  - blink_mask is sampled every cycle, not only at load.
- Without the macro:
  - blink_mask is unused and no counter is synthesised.
  - seg_pins change only in UPDATE or on reset.

Decomposition:
- Shared package seg7_pkg holds:
  - state enum (IDLE, CONVERT, UPDATE)
  - SEG_DASH and SEG_BLANK constants (active-high form)
  - 16-entry active-high glyph constant table
  - bit-index-to-digit offset function
- One sub-module, seg7_encoder: combinational 4-bit nibble plus blank/dash/polarity in, 7-bit pattern out. Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Defaults; decimal 1234, blank_lz=1 → at T+18: d0=19, d1=30, d2=24, d3=79, d4=7F; overflow=0; load_ready low T+1..T+17.
- Hex 16'hBEEF, blank_lz=0 → at T+2: d0=0E, d1=06, d2=06, d3=03, d4=40.
- Decimal 0, blank_lz=1 → d0=40, d1..d4=7F. Decimal 65535 → 5,3,5,5,6 = 12,30,12,12,02; overflow=0.
- NUM_DIGITS=4; decimal 12345 → all digits 3F, overflow=1. Next load 99 → overflow=0.
- Assert reset_reset_n low at T+5 of a decimal conversion → seg_pins=7F immediately, load_ready=1 after release. load_valid pulsed during busy → ignored, display unchanged.
- SEG7_BLINK_EN, BLINK_DIV=4, blink_mask=5'b00001, value 7 → d0 alternates 78/7F every 4 cycles; d1..d4 steady.
